serial_word_receiver: RTL and testbench
=======================================

# serial_word_receiver

Serial-to-parallel receiving end of the 4-bit universal shift register link. The transmitting register shifts a framed word out one bit per strobe; this block detects the start bit, shifts the data bits into an internal register, checks the stop bit, and presents the assembled word on a parallel port with a valid/ack handshake. It sits downstream of the transmitter in the same clock domain and flags framing errors and unacknowledged overwrites.

## Interface

Parameters:
- WIDTH, 4, data bits per frame; legal range 2..16.
- MSB_FIRST, 1, 1 = first data bit received is the MSB (right-shift transmitter); 0 = first data bit is the LSB.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- bit_en  input  1  bit strobe; serial_in is sampled only in cycles where bit_en=1.
- serial_in  input  1  serial line; idles high.
- data_ack  input  1  consumer accepts data_out while data_valid=1.
- data_out  output  WIDTH  last correctly framed word.
- data_valid  output  1  data_out holds an unacknowledged word.
- frame_error  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  sticky: a new word overwrote an unacknowledged one.
- busy  output  1  high in DATA and STOP states.

## Operation

- Frame: start bit 0, WIDTH data bits, stop bit 1; one bit per bit_en strobe. Gaps of any length between strobes are legal.
- States: IDLE, DATA, STOP. bit counter 0..WIDTH-1, internal shift register sh[WIDTH-1:0].
- IDLE: on bit_en & serial_in=0 -> DATA, counter=0, sh=0. bit_en & serial_in=1 -> stay IDLE.
- DATA: on each bit_en, shift serial_in in. MSB_FIRST=1: sh <= {sh[WIDTH-2:0], serial_in}. MSB_FIRST=0: sh <= {serial_in, sh[WIDTH-1:1]}. On the strobe with counter=WIDTH-1 -> STOP; otherwise counter+1.
- STOP, on bit_en:
  - serial_in=1: data_out <= sh, data_valid <= 1; if data_valid was 1 and data_ack=0 in that cycle, overrun <= 1. -> IDLE.
  - serial_in=0: frame_error pulses for one cycle; data_out, data_valid, overrun unchanged; -> IDLE (no re-sync on this 0).
- Handshake: data_ack=1 while data_valid=1 clears data_valid next cycle and clears overrun. data_ack with data_valid=0 is ignored.
- Simultaneous word completion and data_ack: completion wins; data_valid stays 1 with the new word, overrun not set, existing overrun cleared.
- busy = (state != IDLE).

## Timing

- Reset (clear=0 at a rising edge): state=IDLE, counter=0, sh=0, data_out=0, data_valid=0, frame_error=0, overrun=0, busy=0. Overrides every other input that cycle, including mid-frame; the partial frame is discarded.
- Start bit at edge n -> busy=1 after edge n.
- Latency: data_valid and data_out update at the edge that samples the stop bit; visible the following cycle. Minimum frame = WIDTH+2 strobes.
- frame_error high for exactly the one cycle following the stop-bit edge.
- data_valid falls the cycle after the edge where data_ack=1 is sampled.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan

- Reset: hold clear=0 for 2 cycles with random bit_en/serial_in -> all outputs 0, busy=0.
- WIDTH=4, MSB_FIRST=1, bit_en every cycle, send 0,1,0,1,0,1 (start, 1010, stop) -> data_out=4'b1010, data_valid=1 one cycle after the stop edge; data_ack=1 for one cycle -> data_valid=0 next cycle.
- MSB_FIRST=0, bit_en every third cycle, send start, 1,1,0,0, stop -> data_out=4'b0011; busy high throughout the frame.
- Bad stop: start, 1111, stop=0 -> frame_error one-cycle pulse, data_valid stays 0, data_out stays 0; next valid frame 0110 received normally.
- Overrun: receive 1010 without ack, then 0101 -> data_out=4'b0101, overrun=1; data_ack -> overrun=0, data_valid=0. Repeat with data_ack asserted in the stop-bit cycle -> overrun stays 0, data_valid=1.
- Reset mid-frame: start, 2 data bits, clear=0 one cycle -> IDLE, busy=0; next full frame 1001 -> data_out=4'b1001.

Source files
------------

// File: rtl/serial_word_receiver.sv
// Receiving end of the framed serial link: start bit, WIDTH data bits, stop bit,
// one bit per bit_en strobe; assembled word is offered on a valid/ack port.
module serial_word_receiver #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             bit_en,
    input  logic             serial_in,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_error,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               frame_error_q, frame_error_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   sh_shifted;

    // Bit order is fixed at elaboration: MSB-first fills from the right.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sh_shifted = {sh_q[WIDTH-2:0], serial_in};
        end else begin : g_lsb_first
            assign sh_shifted = {serial_in, sh_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sh_d          = sh_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        frame_error_d = 1'b0;
        overrun_d     = overrun_q;

        if (data_valid_q && data_ack) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bit_en && !serial_in) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
            DATA: begin
                if (bit_en) begin
                    sh_d = sh_shifted;
                    if (cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (bit_en) begin
                    state_d = IDLE;
                    if (serial_in) begin
                        // A completing word wins over a same-cycle ack.
                        data_out_d   = sh_q;
                        data_valid_d = 1'b1;
                        if (data_valid_q && !data_ack) begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sh_q          <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sh_q          <= sh_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: an MSB-first and an LSB-first instance share
// one serial line; expected words go through a scoreboard queue per instance.
module tb_serial_word_receiver;

    logic       clk = 1'b0;
    logic       clear;
    logic       bit_en;
    logic       serial_in;
    logic       data_ack;

    logic [3:0] m_data_out, l_data_out;
    logic       m_data_valid, l_data_valid;
    logic       m_frame_error, l_frame_error;
    logic       m_overrun, l_overrun;
    logic       m_busy, l_busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] exp_m_q[$];
    logic [3:0] exp_l_q[$];

    // Reference state of the consumer-visible outputs.
    logic       model_valid;
    logic       model_ovr;
    logic [3:0] model_dout_m;
    logic [3:0] model_dout_l;

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk        (clk),
        .clear      (clear),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .data_ack   (data_ack),
        .data_out   (m_data_out),
        .data_valid (m_data_valid),
        .frame_error(m_frame_error),
        .overrun    (m_overrun),
        .busy       (m_busy)
    );

    serial_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk        (clk),
        .clear      (clear),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .data_ack   (data_ack),
        .data_out   (l_data_out),
        .data_valid (l_data_valid),
        .frame_error(l_frame_error),
        .overrun    (l_overrun),
        .busy       (l_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rev4(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic check_status(input string tag);
        check({tag, " m_valid"}, 32'(m_data_valid), 32'(model_valid));
        check({tag, " l_valid"}, 32'(l_data_valid), 32'(model_valid));
        check({tag, " m_ovr"},   32'(m_overrun),    32'(model_ovr));
        check({tag, " l_ovr"},   32'(l_overrun),    32'(model_ovr));
        check({tag, " m_dout"},  32'(m_data_out),   32'(model_dout_m));
        check({tag, " l_dout"},  32'(l_data_out),   32'(model_dout_l));
    endtask

    // Idle gap cycles first, then one strobed bit; returns 1 time unit after the edge.
    task automatic strobe(input logic b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        serial_in = b;
        bit_en    = 1'b1;
        @(posedge clk);
        #1;
        bit_en    = 1'b0;
        serial_in = 1'b1;
    endtask

    task automatic send_frame(input string tag, input logic [3:0] w, input logic stop_bit,
                              input int gap, input logic ack_at_stop);
        logic [3:0] em, el;
        if (stop_bit) begin
            exp_m_q.push_back(w);
            exp_l_q.push_back(rev4(w));
        end
        strobe(1'b0, gap);
        check({tag, " busy_start_m"}, 32'(m_busy), 32'd1);
        check({tag, " busy_start_l"}, 32'(l_busy), 32'd1);
        for (int i = 3; i >= 0; i--) begin
            strobe(w[i], gap);
            check({tag, " busy_data"}, 32'(m_busy & l_busy), 32'd1);
        end
        repeat (gap) @(posedge clk);
        #1;
        data_ack  = ack_at_stop;
        serial_in = stop_bit;
        bit_en    = 1'b1;
        @(posedge clk);
        #1;
        bit_en    = 1'b0;
        serial_in = 1'b1;
        data_ack  = 1'b0;
        if (stop_bit) begin
            model_ovr    = (model_valid && !ack_at_stop) ? 1'b1 :
                           ((model_valid && ack_at_stop) ? 1'b0 : model_ovr);
            model_valid  = 1'b1;
            if (exp_m_q.size() == 0 || exp_l_q.size() == 0) begin
                check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
            end else begin
                em = exp_m_q.pop_front();
                el = exp_l_q.pop_front();
                model_dout_m = em;
                model_dout_l = el;
            end
            check({tag, " ferr_m"}, 32'(m_frame_error), 32'd0);
        end else begin
            check({tag, " ferr_m"}, 32'(m_frame_error), 32'd1);
            check({tag, " ferr_l"}, 32'(l_frame_error), 32'd1);
        end
        check({tag, " busy_end"}, 32'(m_busy | l_busy), 32'd0);
        check_status(tag);
        $display("[TB] frame %s word=%b stop=%b -> m_out=%b l_out=%b valid=%b ovr=%b ferr=%b",
                 tag, w, stop_bit, m_data_out, l_data_out, m_data_valid, m_overrun, m_frame_error);
        if (!stop_bit) begin
            @(posedge clk);
            #1;
            check({tag, " ferr_pulse_end"}, 32'(m_frame_error | l_frame_error), 32'd0);
        end
    endtask

    task automatic ack_pulse(input string tag);
        data_ack = 1'b1;
        @(posedge clk);
        #1;
        data_ack = 1'b0;
        if (model_valid) begin
            model_valid = 1'b0;
            model_ovr   = 1'b0;
        end
        check_status(tag);
        $display("[TB] ack %s -> valid=%b ovr=%b", tag, m_data_valid, m_overrun);
    endtask

    initial begin
        clear        = 1'b0;
        bit_en       = 1'b0;
        serial_in    = 1'b1;
        data_ack     = 1'b0;
        model_valid  = 1'b0;
        model_ovr    = 1'b0;
        model_dout_m = 4'd0;
        model_dout_l = 4'd0;

        // Reset with noisy inputs
        repeat (2) begin
            bit_en    = 1'($urandom_range(0, 1));
            serial_in = 1'($urandom_range(0, 1));
            data_ack  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bit_en    = 1'b0;
        serial_in = 1'b1;
        data_ack  = 1'b0;
        clear     = 1'b1;
        check("reset busy",  32'(m_busy | l_busy), 32'd0);
        check("reset ferr",  32'(m_frame_error | l_frame_error), 32'd0);
        check_status("reset");
        $display("[TB] reset done");

        // Bad stop bit right after reset, then a clean frame
        send_frame("bad_stop", 4'b1111, 1'b0, 0, 1'b0);
        send_frame("after_bad", 4'b0110, 1'b1, 0, 1'b0);
        ack_pulse("after_bad");

        // Back-to-back strobes and slow strobes (every third cycle)
        send_frame("msb_1010", 4'b1010, 1'b1, 0, 1'b0);
        ack_pulse("msb_1010");
        send_frame("slow_1100", 4'b1100, 1'b1, 2, 1'b0);
        ack_pulse("slow_1100");

        // Overrun without ack, then ack clears both flags
        send_frame("ovr_a", 4'b1010, 1'b1, 0, 1'b0);
        send_frame("ovr_b", 4'b0101, 1'b1, 1, 1'b0);
        ack_pulse("ovr_clear");

        // Ack in the stop-bit cycle: completion wins, no overrun
        send_frame("ackstop_a", 4'b1010, 1'b1, 0, 1'b0);
        send_frame("ackstop_b", 4'b0101, 1'b1, 0, 1'b1);
        ack_pulse("ackstop_clear");

        // Clear mid-frame discards the partial word
        send_frame("pre_rst", 4'b0111, 1'b1, 0, 1'b0);
        strobe(1'b0, 0);
        strobe(1'b1, 0);
        strobe(1'b0, 0);
        clear     = 1'b0;
        bit_en    = 1'b1;
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        clear        = 1'b1;
        bit_en       = 1'b0;
        serial_in    = 1'b1;
        model_valid  = 1'b0;
        model_ovr    = 1'b0;
        model_dout_m = 4'd0;
        model_dout_l = 4'd0;
        check("midrst busy", 32'(m_busy | l_busy), 32'd0);
        check_status("midrst");
        $display("[TB] mid-frame clear done");
        send_frame("post_rst", 4'b1001, 1'b1, 0, 1'b0);
        send_frame("post_rst2", 4'b0011, 1'b1, 1, 1'b1);
        ack_pulse("post_rst2");

        check("scoreboard drained", 32'(exp_m_q.size() + exp_l_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
